i2c_slave_memory_p: RTL

Parametrised next-generation I2C slave register memory, clocked from the system clock instead of SCL. It oversamples SCL/SDA, detects START, repeated START and STOP, and decodes a configurable 7-bit address. It serves multi-byte writes and reads through an auto-incrementing register pointer. It sits behind the bridge's I2C master as the bus-side target model and local register file.

---
 rtl/i2c_pkg.sv | 33 +++
 rtl/i2c_bus_filter.sv | 81 ++++++++
 rtl/i2c_slave_memory_p.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/i2c_pkg.sv
// ---------------------------------------------------------------------------
// i2c_pkg: shared state encoding and bus constants for the I2C slave memory.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package i2c_pkg;

  typedef enum logic [3:0] {
    S_IDLE       = 4'd0,
    S_ADDR       = 4'd1,
    S_ADDR_ACK   = 4'd2,
    S_PTR        = 4'd3,
    S_PTR_ACK    = 4'd4,
    S_WDATA      = 4'd5,
    S_WDATA_ACK  = 4'd6,
    S_RDATA      = 4'd7,
    S_RDATA_MACK = 4'd8,
    S_IGNORE     = 4'd9
  } i2c_slv_state_t;

  localparam logic I2C_ACK  = 1'b0;
  localparam logic I2C_NACK = 1'b1;
  localparam logic I2C_WR   = 1'b0;
  localparam logic I2C_RD   = 1'b1;

  function automatic int ptr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/i2c_bus_filter.sv
// ---------------------------------------------------------------------------
// i2c_bus_filter: 2-FF sync, run-length glitch filter and SCL/SDA event detect.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module i2c_bus_filter #(
  parameter int FILTER_LEN = 3
) (
  input  logic clk,
  input  logic rst_n,
  input  logic scl_i,
  input  logic sda_i,
  output logic scl_rise,
  output logic scl_fall,
  output logic start_det,
  output logic stop_det,
  output logic sda_f
);

  localparam logic [2:0] RUN_MAX = 3'(FILTER_LEN - 1);

  // Bit 0 carries SCL, bit 1 carries SDA throughout.
  logic [1:0]      sync1_q, sync2_q, filt_q, filt_d, prev_q;
  logic [1:0][2:0] cnt_q, cnt_d;
  logic            rise_q, rise_d, fall_q, fall_d;
  logic            start_q, start_d, stop_q, stop_d, sda_f_q;

  always_comb begin
    filt_d = filt_q;
    cnt_d  = '0;
    for (int i = 0; i < 2; i++) begin
      if (sync2_q[i] != filt_q[i]) begin
        if (cnt_q[i] == RUN_MAX) begin
          filt_d[i] = sync2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + 3'd1;
        end
      end
    end
    rise_d  = filt_q[0] & ~prev_q[0];
    fall_d  = ~filt_q[0] & prev_q[0];
    start_d = prev_q[1] & ~filt_q[1] & filt_q[0] & prev_q[0];
    stop_d  = ~prev_q[1] & filt_q[1] & filt_q[0] & prev_q[0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 2'b11;
      sync2_q <= 2'b11;
      filt_q  <= 2'b11;
      prev_q  <= 2'b11;
      cnt_q   <= '0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
      start_q <= 1'b0;
      stop_q  <= 1'b0;
      sda_f_q <= 1'b1;
    end else begin
      sync1_q <= {sda_i, scl_i};
      sync2_q <= sync1_q;
      filt_q  <= filt_d;
      prev_q  <= filt_q;
      cnt_q   <= cnt_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
      start_q <= start_d;
      stop_q  <= stop_d;
      sda_f_q <= filt_q[1];
    end
  end

  assign scl_rise  = rise_q;
  assign scl_fall  = fall_q;
  assign start_det = start_q;
  assign stop_det  = stop_q;
  assign sda_f     = sda_f_q;

endmodule

`default_nettype wire

// File: rtl/i2c_slave_memory_p.sv
// ---------------------------------------------------------------------------
// i2c_slave_memory_p: system-clocked I2C slave register file with auto-increment.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module i2c_slave_memory_p
  import i2c_pkg::*;
#(
  parameter logic [6:0] SLAVE_ADDR = 7'h0B,
  parameter int         MEM_DEPTH  = 16,
  parameter int         FILTER_LEN = 3,
  parameter logic [7:0] INIT_VAL   = 8'h00
) (
  input  logic                            CLK,
  input  logic                            RESETn,
  input  logic                            s_scl_i,
  input  logic                            s_sda_i,
  output logic                            s_sda_o,
  output logic                            s_sda_o_en,
  output logic                            busy,
  output logic                            wr_pulse,
  output logic [ptr_width(MEM_DEPTH)-1:0] wr_addr,
  output logic [7:0]                      wr_data
);

  localparam int PW = ptr_width(MEM_DEPTH);

  logic scl_rise, scl_fall, start_det, stop_det, sda_f;

  i2c_bus_filter #(
    .FILTER_LEN (FILTER_LEN)
  ) u_filter (
    .clk       (CLK),
    .rst_n     (RESETn),
    .scl_i     (s_scl_i),
    .sda_i     (s_sda_i),
    .scl_rise  (scl_rise),
    .scl_fall  (scl_fall),
    .start_det (start_det),
    .stop_det  (stop_det),
    .sda_f     (sda_f)
  );

  i2c_slv_state_t state_q, state_d;
  logic [3:0]     bit_cnt_q, bit_cnt_d;
  logic [7:0]     shift_q, shift_d;
  logic [PW-1:0]  ptr_q, ptr_d;
  logic           sda_en_q, sda_en_d;
  logic           busy_q, busy_d;
  logic           wr_pulse_q, wr_pulse_d;
  logic [PW-1:0]  wr_addr_q, wr_addr_d;
  logic [7:0]     wr_data_q, wr_data_d;
  logic           mem_we;
  logic [7:0]     rx_byte;
  logic [7:0]     mem_q [MEM_DEPTH];

  assign rx_byte = {shift_q[6:0], sda_f};

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      state_q    <= S_IDLE;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      ptr_q      <= '0;
      sda_en_q   <= 1'b0;
      busy_q     <= 1'b0;
      wr_pulse_q <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      ptr_q      <= ptr_d;
      sda_en_q   <= sda_en_d;
      busy_q     <= busy_d;
      wr_pulse_q <= wr_pulse_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
    end
  end

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      for (int i = 0; i < MEM_DEPTH; i++) begin
        mem_q[i] <= INIT_VAL;
      end
    end else if (mem_we) begin
      mem_q[ptr_q] <= rx_byte;
    end
  end

  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    ptr_d      = ptr_q;
    sda_en_d   = sda_en_q;
    busy_d     = busy_q;
    wr_pulse_d = 1'b0;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    mem_we     = 1'b0;

    // Bus conditions take priority over any bit event in the same cycle.
    if (start_det) begin
      state_d   = S_ADDR;
      bit_cnt_d = '0;
      busy_d    = 1'b1;
      sda_en_d  = 1'b0;
    end else if (stop_det) begin
      state_d  = S_IDLE;
      busy_d   = 1'b0;
      sda_en_d = 1'b0;
    end else begin
      case (state_q)
        S_ADDR, S_PTR, S_WDATA: begin
          if (scl_rise && (bit_cnt_q < 4'd8)) begin
            shift_d   = rx_byte;
            bit_cnt_d = bit_cnt_q + 4'd1;
            if ((state_q == S_WDATA) && (bit_cnt_q == 4'd7)) begin
              mem_we     = 1'b1;
              wr_pulse_d = 1'b1;
              wr_addr_d  = ptr_q;
              wr_data_d  = rx_byte;
            end
          end else if (scl_fall && (bit_cnt_q == 4'd8)) begin
            if (state_q == S_ADDR) begin
              if (shift_q[7:1] == SLAVE_ADDR) begin
                state_d  = S_ADDR_ACK;
                sda_en_d = 1'b1;
              end else begin
                state_d = S_IGNORE;
              end
            end else if (state_q == S_PTR) begin
              if (int'(shift_q) < MEM_DEPTH) begin
                ptr_d    = shift_q[PW-1:0];
                state_d  = S_PTR_ACK;
                sda_en_d = 1'b1;
              end else begin
                state_d = S_IGNORE;
              end
            end else begin
              state_d  = S_WDATA_ACK;
              sda_en_d = 1'b1;
            end
          end
        end
        S_ADDR_ACK: begin
          if (scl_fall) begin
            if (shift_q[0] == I2C_RD) begin
              state_d   = S_RDATA;
              shift_d   = mem_q[ptr_q];
              sda_en_d  = ~mem_q[ptr_q][7];
              bit_cnt_d = 4'd1;
            end else begin
              state_d   = S_PTR;
              sda_en_d  = 1'b0;
              bit_cnt_d = '0;
            end
          end
        end
        S_PTR_ACK, S_WDATA_ACK: begin
          if (scl_fall) begin
            state_d   = S_WDATA;
            sda_en_d  = 1'b0;
            bit_cnt_d = '0;
            if (state_q == S_WDATA_ACK) begin
              ptr_d = ptr_q + PW'(1);
            end
          end
        end
        // bit_cnt counts bits already placed on the bus; 0 means reload.
        S_RDATA: begin
          if (scl_fall) begin
            if (bit_cnt_q == 4'd0) begin
              shift_d   = mem_q[ptr_q];
              sda_en_d  = ~mem_q[ptr_q][7];
              bit_cnt_d = 4'd1;
            end else if (bit_cnt_q == 4'd8) begin
              state_d  = S_RDATA_MACK;
              sda_en_d = 1'b0;
            end else begin
              shift_d   = {shift_q[6:0], 1'b0};
              sda_en_d  = ~shift_q[6];
              bit_cnt_d = bit_cnt_q + 4'd1;
            end
          end
        end
        // The pointer advances past every byte handed to the master.
        S_RDATA_MACK: begin
          if (scl_rise) begin
            ptr_d = ptr_q + PW'(1);
            if (sda_f == I2C_NACK) begin
              state_d = S_IGNORE;
            end else begin
              state_d   = S_RDATA;
              bit_cnt_d = '0;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    s_sda_o    = 1'b0;
    s_sda_o_en = sda_en_q;
    busy       = busy_q;
    wr_pulse   = wr_pulse_q;
    wr_addr    = wr_addr_q;
    wr_data    = wr_data_q;
  end

endmodule

`default_nettype wire
